rs_syn_stream: RTL and testbench

RS_SYN_STREAM -- requirements
Module: rs_syn_stream

---
 rtl/rs_syn_stream_if.sv | 24 ++
 rtl/rs_syn_stream.sv | 175 +++++++++++++++++
 tb/tb_rs_syn_stream.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rs_syn_stream_if.sv
// Stream-in / syndrome-out handshake bundle for the RS syndrome calculator.
interface rs_syn_stream_if #(
  parameter int unsigned NPAR = 32
);
  logic                s_valid;
  logic                s_ready;
  logic [7:0]          s_data;
  logic                s_last;
  logic                syn_valid;
  logic                syn_ready;
  logic [8*NPAR-1:0]   syn_data;
  logic                syn_nonzero;
  logic                len_err;

  modport slave (
    input  s_valid, s_data, s_last, syn_ready,
    output s_ready, syn_valid, syn_data, syn_nonzero, len_err
  );

  modport master (
    output s_valid, s_data, s_last, syn_ready,
    input  s_ready, syn_valid, syn_data, syn_nonzero, len_err
  );
endinterface

// File: rtl/rs_syn_stream.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^8): Horner accumulation
// per root, with a one-deep pending buffer behind the output register.
module rs_syn_stream #(
  parameter int unsigned NPAR = 32,
  parameter int unsigned FCR  = 0,
  parameter logic [8:0]  PRIM = 9'h11D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      cfg_k,
  rs_syn_stream_if.slave  bus
);

  localparam int unsigned SW = 8;
  localparam int unsigned CW = 9;

  typedef logic [NPAR-1:0][SW-1:0] syn_t;

  function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] x);
    return {x[SW-2:0], 1'b0} ^ (x[SW-1] ? PRIM[SW-1:0] : SW'(0));
  endfunction

  // Shift-and-add multiply; with a constant b this folds into an xor network.
  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] p;
    logic [SW-1:0] x;
    p = '0;
    x = a;
    for (int unsigned j = 0; j < SW; j++) begin
      if (b[j]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [SW-1:0] gf_pow(input int unsigned e);
    logic [SW-1:0] p;
    p = SW'(1);
    for (int unsigned j = 0; j < 255; j++) begin
      if (j < (e % 255)) p = gf_xtime(p);
    end
    return p;
  endfunction

  function automatic syn_t calc_roots();
    syn_t r;
    r = '0;
    for (int unsigned i = 0; i < NPAR; i++) r[i] = gf_pow(FCR + i);
    return r;
  endfunction

  localparam syn_t ROOTS = calc_roots();

  syn_t            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      k_q, k_d;
  logic            first_q, first_d;
  logic            lerr_q, lerr_d;
  logic            rdy_q, rdy_d;
  logic            out_vld_q, out_vld_d;
  syn_t            out_syn_q, out_syn_d;
  logic            out_nz_q, out_nz_d;
  logic            out_lerr_q, out_lerr_d;
  logic            pend_vld_q, pend_vld_d;
  syn_t            pend_syn_q, pend_syn_d;
  logic            pend_nz_q, pend_nz_d;
  logic            pend_lerr_q, pend_lerr_d;

  syn_t            syn_nxt;
  logic            beat, drain, err_nxt, nz_nxt;
  logic [7:0]      frame_k;
  logic [CW-1:0]   exp_n, cnt_nxt;

  // Per-root Horner step: S_i * alpha^(FCR+i) xor incoming symbol.
  for (genvar gi = 0; gi < NPAR; gi++) begin : g_root
    assign syn_nxt[gi] = first_q ? bus.s_data : (gf_mul(acc_q[gi], ROOTS[gi]) ^ bus.s_data);
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    first_d     = first_q;
    lerr_d      = lerr_q;
    out_vld_d   = out_vld_q;
    out_syn_d   = out_syn_q;
    out_nz_d    = out_nz_q;
    out_lerr_d  = out_lerr_q;
    pend_vld_d  = pend_vld_q;
    pend_syn_d  = pend_syn_q;
    pend_nz_d   = pend_nz_q;
    pend_lerr_d = pend_lerr_q;

    beat    = bus.s_valid & rdy_q;
    drain   = out_vld_q & bus.syn_ready;
    frame_k = first_q ? cfg_k : k_q;
    exp_n   = CW'(frame_k) + CW'(NPAR);
    cnt_nxt = first_q ? CW'(1) : cnt_q + CW'(1);
    err_nxt = (~first_q & lerr_q) |
              (bus.s_last ? (cnt_nxt != exp_n) : (cnt_nxt == exp_n));
    nz_nxt  = |syn_nxt;

    if (beat) begin
      acc_d   = syn_nxt;
      k_d     = frame_k;
      first_d = bus.s_last;
      cnt_d   = bus.s_last ? '0 : cnt_nxt;
      lerr_d  = bus.s_last ? 1'b0 : err_nxt;
    end

    // Finished frame goes straight out when the output slot frees, else parks.
    if (beat && bus.s_last && (!out_vld_q || drain)) begin
      out_vld_d  = 1'b1;
      out_syn_d  = syn_nxt;
      out_nz_d   = nz_nxt;
      out_lerr_d = err_nxt;
    end else if (beat && bus.s_last) begin
      pend_vld_d  = 1'b1;
      pend_syn_d  = syn_nxt;
      pend_nz_d   = nz_nxt;
      pend_lerr_d = err_nxt;
    end else if (drain) begin
      out_vld_d = pend_vld_q;
      if (pend_vld_q) begin
        out_syn_d  = pend_syn_q;
        out_nz_d   = pend_nz_q;
        out_lerr_d = pend_lerr_q;
        pend_vld_d = 1'b0;
      end
    end

    rdy_d = ~pend_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      first_q     <= 1'b1;
      lerr_q      <= 1'b0;
      rdy_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_syn_q   <= '0;
      out_nz_q    <= 1'b0;
      out_lerr_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_syn_q  <= '0;
      pend_nz_q   <= 1'b0;
      pend_lerr_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      first_q     <= first_d;
      lerr_q      <= lerr_d;
      rdy_q       <= rdy_d;
      out_vld_q   <= out_vld_d;
      out_syn_q   <= out_syn_d;
      out_nz_q    <= out_nz_d;
      out_lerr_q  <= out_lerr_d;
      pend_vld_q  <= pend_vld_d;
      pend_syn_q  <= pend_syn_d;
      pend_nz_q   <= pend_nz_d;
      pend_lerr_q <= pend_lerr_d;
    end
  end

  assign bus.s_ready     = rdy_q;
  assign bus.syn_valid   = out_vld_q;
  assign bus.syn_data    = out_syn_q;
  assign bus.syn_nonzero = out_nz_q;
  assign bus.len_err     = out_lerr_q;

endmodule

// File: tb/tb_rs_syn_stream.sv
// Directed bench for rs_syn_stream: table of single-error frames checked against
// a log/antilog GF(2^8) model, plus backpressure and mid-frame reset sequences.
module tb_rs_syn_stream;
  localparam int unsigned NPAR = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_k;

  always #5 clk = ~clk;

  rs_syn_stream_if #(.NPAR(NPAR)) bus ();

  rs_syn_stream #(.NPAR(NPAR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cfg_k(cfg_k),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_t [255];
  int         log_t [256];

  typedef struct {
    string      nm;
    int         k;
    int         nb;
    int         pos;
    logic [7:0] val;
    bit         kchg;
    int         s1;
    int         s8;
    bit         nz;
    bit         le;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Single nonzero symbol val at beat pos (of nb): S_i = val * alpha^(d*i).
  function automatic logic [255:0] model(input int nb, input int pos, input logic [7:0] val);
    logic [255:0] r;
    int d;
    r = '0;
    d = nb - 1 - pos;
    if (pos >= 0)
      for (int i = 0; i < 32; i++) r[8*i +: 8] = gmul(val, exp_t[(d * i) % 255]);
    return r;
  endfunction

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.s_ready && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.s_ready) chk("s_ready_wait", 256'(bus.s_ready), 256'(1));
  endtask

  task automatic send_frame(input int k, input int nb, input int pos,
                            input logic [7:0] val, input bit kchg);
    cfg_k = 8'(k);
    for (int b = 0; b < nb; b++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (b == pos) ? val : 8'h00;
      bus.s_last  = (b == nb - 1);
      wait_ready();
      @(posedge clk); #1;
      if (kchg && b == 0) cfg_k = 8'd5;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic drain_out(input string nm);
    bus.syn_ready = 1'b1;
    @(posedge clk); #1;
    bus.syn_ready = 1'b0;
    chk({nm, "_drained"}, 256'(bus.syn_valid), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] x;
    logic [255:0] snap;

    rst_n         = 1'b0;
    cfg_k         = 8'd223;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.s_last    = 1'b0;
    bus.syn_ready = 1'b0;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end

    vt[0] = '{"zeros",      223, 255,  -1, 8'h00, 1'b0, 'h00, 'h00, 1'b0, 1'b0};
    vt[1] = '{"last_one",   223, 255, 254, 8'h01, 1'b0, 'h01, 'h01, 1'b1, 1'b0};
    vt[2] = '{"second_last",223, 255, 253, 8'h01, 1'b0, 'h02, 'h1D, 1'b1, 1'b0};
    vt[3] = '{"shortened",  100, 132,   0, 8'h01, 1'b0,   -1,   -1, 1'b1, 1'b0};
    vt[4] = '{"early_last", 223, 100,  -1, 8'h00, 1'b0, 'h00, 'h00, 1'b0, 1'b1};
    vt[5] = '{"good_kchg",  223, 255, 254, 8'h01, 1'b1, 'h01, 'h01, 1'b1, 1'b0};
    vt[6] = '{"single",     223,   1,   0, 8'h37, 1'b0, 'h37, 'h37, 1'b1, 1'b1};
    vt[7] = '{"too_long",    10,  50,  49, 8'h01, 1'b0, 'h01, 'h01, 1'b1, 1'b1};
    vt[8] = '{"k0_deg2",      0,  32,  29, 8'h05, 1'b0, 'h14, 'h61, 1'b1, 1'b0};

    #12;
    chk("rst_syn_valid", 256'(bus.syn_valid),   256'(0));
    chk("rst_s_ready",   256'(bus.s_ready),     256'(0));
    chk("rst_syn_data",  256'(bus.syn_data),    256'(0));
    chk("rst_nonzero",   256'(bus.syn_nonzero), 256'(0));
    chk("rst_len_err",   256'(bus.len_err),     256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 256'(bus.s_ready), 256'(0));
    @(posedge clk); #1;
    chk("s_ready_after_edge", 256'(bus.s_ready), 256'(1));

    for (int i = 0; i < 9; i++) begin
      send_frame(vt[i].k, vt[i].nb, vt[i].pos, vt[i].val, vt[i].kchg);
      chk({vt[i].nm, "_valid"},   256'(bus.syn_valid),   256'(1));
      chk({vt[i].nm, "_data"},    256'(bus.syn_data),    model(vt[i].nb, vt[i].pos, vt[i].val));
      chk({vt[i].nm, "_nonzero"}, 256'(bus.syn_nonzero), 256'(vt[i].nz));
      chk({vt[i].nm, "_len_err"}, 256'(bus.len_err),     256'(vt[i].le));
      if (vt[i].s1 >= 0) chk({vt[i].nm, "_S1"}, 256'(bus.syn_data[15:8]), 256'(vt[i].s1));
      if (vt[i].s8 >= 0) chk({vt[i].nm, "_S8"}, 256'(bus.syn_data[71:64]), 256'(vt[i].s8));
      snap = bus.syn_data;
      @(posedge clk); #1;
      chk({vt[i].nm, "_held"}, 256'(bus.syn_data), snap);
      drain_out(vt[i].nm);
    end

    // Two frames back to back with the output stalled.
    send_frame(0, 32, 31, 8'h01, 1'b0);
    chk("bp_rdy_after_f1", 256'(bus.s_ready),   256'(1));
    chk("bp_valid_f1",     256'(bus.syn_valid), 256'(1));
    send_frame(0, 32, 0, 8'h02, 1'b0);
    chk("bp_rdy_drop",  256'(bus.s_ready),  256'(0));
    chk("bp_first_out", 256'(bus.syn_data), model(32, 31, 8'h01));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_rdy_held_low", 256'(bus.s_ready),  256'(0));
    chk("bp_first_stable", 256'(bus.syn_data), model(32, 31, 8'h01));
    bus.syn_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rdy_rise",   256'(bus.s_ready),   256'(1));
    chk("bp_valid_f2",   256'(bus.syn_valid), 256'(1));
    chk("bp_second_out", 256'(bus.syn_data),  model(32, 0, 8'h02));
    chk("bp_second_lerr",256'(bus.len_err),   256'(0));
    @(posedge clk); #1;
    bus.syn_ready = 1'b0;
    chk("bp_empty", 256'(bus.syn_valid), 256'(0));

    // Reset with a result waiting and a frame half received.
    send_frame(0, 32, 31, 8'h01, 1'b0);
    for (int b = 0; b < 10; b++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      bus.s_last  = 1'b0;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    chk("midrst_valid",   256'(bus.syn_valid), 256'(0));
    chk("midrst_s_ready", 256'(bus.s_ready),   256'(0));
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 32, 28, 8'h01, 1'b0);
    chk("post_rst_valid", 256'(bus.syn_valid),   256'(1));
    chk("post_rst_data",  256'(bus.syn_data),    model(32, 28, 8'h01));
    chk("post_rst_S1",    256'(bus.syn_data[15:8]), 256'(8'h08));
    chk("post_rst_nz",    256'(bus.syn_nonzero), 256'(1));
    chk("post_rst_lerr",  256'(bus.len_err),     256'(0));
    drain_out("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
